data_mem_responder: RTL

Multi-cycle data-memory responder for the pipelined CPU's MEM stage. It accepts one load or store request at a time from the pipeline, completes it after a fixed latency, and returns read data with a one-cycle valid pulse. While a request is outstanding it holds `busy_o` high to stall the pipeline. It also keeps a saturating count of stall cycles, so benches can cross-check the hazard unit's stall accounting.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/data_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU memory-stage blocks: FSM state encoding,
// default geometry and the address legality check used by the responder.
package cpu_pkg;

    // Machine word width in bits.
    localparam int XLEN        = 32;

    // Default memory size in bytes and default number of WAIT cycles.
    localparam int DEF_DEPTH   = 32;
    localparam int DEF_LATENCY = 2;

    // Responder FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // A word access is legal only when it is aligned and all four bytes
    // lie inside the array. There is no wrap-around.
    function automatic logic addr_is_bad(input logic [XLEN-1:0] addr,
                                         input int              depth);
        return (addr[1:0] != 2'b00) || (addr > XLEN'(depth - 4));
    endfunction

endpackage : cpu_pkg

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the MEM stage. One word load or
// store is accepted at a time, completed after LATENCY WAIT cycles, and
// answered with a single-cycle valid pulse. busy_o stalls the pipeline
// while the access is in flight and a saturating counter records how many
// cycles were spent stalled.
module data_mem_responder
    import cpu_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            valid_o,
    output logic            err_o,
    output logic            busy_o,
    output logic [XLEN-1:0] stall_cnt_o
);

    // Byte-address width and the word-index width derived from it.
    localparam int AW    = $clog2(DEPTH);
    localparam int WAW   = AW - 2;
    // Wide enough to hold LATENCY-1; at least one bit.
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    // Flat byte array; benches preload and dump it through this exact name.
    logic [7:0] memory [0:DEPTH-1];

    // FSM state and WAIT down-counter.
    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    // Request captured at acceptance; held stable for the whole access.
    logic             r_we;
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;

    // Response registers.
    logic [XLEN-1:0]  r_rdata;
    logic             r_err;
    logic [XLEN-1:0]  r_stall_cnt;

    // Decoded control.
    logic             w_accept;
    logic             w_access;
    logic             w_err;
    logic             w_do_store;
    logic [WAW-1:0]   w_word_idx;
    logic [XLEN-1:0]  w_rd_word;

    assign w_accept   = (r_state == IDLE) && start_i && req_i;
    assign w_access   = (r_state == WAIT) && (r_cnt == '0);
    assign w_err      = addr_is_bad(r_addr, DEPTH);
    assign w_do_store = w_access && r_we && !w_err;
    assign w_word_idx = r_addr[AW-1:2];

    // Assemble the little-endian word at the latched address, one byte lane
    // per generate iteration (lane 0 is the lowest address).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi = gi + 1) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign w_rd_word[8*gi +: 8] = memory[{w_word_idx, LANE}];
        end
    endgenerate

    // FSM state register; reset returns to IDLE and drops any pending access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // FSM next-state logic: accept in IDLE, count down in WAIT, answer in RESP.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (start_i && req_i) begin
                    w_state_next = WAIT;
                    w_cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                // The requesting instruction is still in MEM, so req_i is
                // deliberately ignored here.
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Request capture and response data; a rejected access returns zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
            end
            if (w_access) begin
                r_err <= w_err;
                if (w_err) begin
                    r_rdata <= '0;
                end else if (!r_we) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    // Store port: all four bytes land on the access edge. Reset on that edge
    // cancels the write; the array itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_do_store) begin
            for (int k = 0; k < 4; k++) begin
                memory[{w_word_idx, 2'(k)}] <= r_wdata[8*k +: 8];
            end
        end
    end

    // Saturating count of cycles in which the pipeline is being stalled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
        end else if (busy_o && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + XLEN'(1);
        end
    end

    // busy_o is low in RESP so the pipeline advances on the edge ending RESP.
    assign busy_o      = w_accept || (r_state == WAIT);
    assign valid_o     = (r_state == RESP);
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign stall_cnt_o = r_stall_cnt;

endmodule : data_mem_responder
